jtdd_sndcmd: RTL and testbench



---
 rtl/jtdd_pkg.sv | 19 +
 rtl/jtdd_sndcmd_if.sv | 25 ++
 rtl/jtdd_sndcmd_fifo.sv | 46 ++++
 rtl/jtdd_sndcmd.sv | 134 +++++++++++++
 tb/tb_jtdd_sndcmd.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtdd_pkg.sv
// Shared definitions for the Double Dragon sound command path.
// Holds the transmitter FSM encoding and the default handshake timing.
package jtdd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_IRQ   = 2'd2,
        ST_GAP   = 2'd3
    } snd_st_t;

    // Latch setup cycles before IRQ and IRQ-low spacing between commands
    localparam int SETUP_DEF = 2;
    localparam int GAP_DEF   = 4;

    // Width of the counter shared by SETUP and GAP
    localparam int CNT_W = 4;

endpackage

// File: rtl/jtdd_sndcmd_if.sv
// Command path between main-CPU decode and the sound-side latch/IRQ pins.
// Master drives the strobes; slave is the transmitter that owns latch, IRQ and flags.
interface jtdd_sndcmd_if;
    logic       cmd_wr;
    logic [7:0] cmd_din;
    logic       flush;
    logic       clr_flags;
    logic       snd_ack;
    logic [7:0] snd_latch;
    logic       snd_irq;
    logic       busy;
    logic       full;
    logic       ovf;
    logic       lost;

    modport master (
        output cmd_wr, cmd_din, flush, clr_flags, snd_ack,
        input  snd_latch, snd_irq, busy, full, ovf, lost
    );

    modport slave (
        input  cmd_wr, cmd_din, flush, clr_flags, snd_ack,
        output snd_latch, snd_irq, busy, full, ovf, lost
    );
endinterface

// File: rtl/jtdd_sndcmd_fifo.sv
// Byte FIFO, 2^AW entries, pointers one bit wider than the address.
// Latency: push visible next cycle, dout is the head combinationally.
// Backpressure: push while full (without pop) and pop while empty are ignored.
module jtdd_sndcmd_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jtdd_sndcmd.sv
// Sound command transmitter: buffers main-CPU bytes and hands them to the sound CPU via latch + IRQ edge.
// Latency: cmd_wr at cycle 0 -> latch at cycle 2 -> IRQ at cycle 2+SETUP; GAP low cycles between commands.
// Backpressure: none upstream; writes into a full FIFO are dropped and flagged on ovf.
module jtdd_sndcmd
    import jtdd_pkg::*;
#(
    parameter int AW    = 2,
    parameter int SETUP = SETUP_DEF,
    parameter int GAP   = GAP_DEF,
    parameter int TOW   = 16
) (
    input  logic          clk,
    input  logic          rstn,
    jtdd_sndcmd_if.slave  bus
);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
    // IRQ lasts 2^TOW-1 cycles, so the last IRQ cycle sees this count
    localparam logic [TOW-1:0]   TO_LAST    = {TOW{1'b1}} - 1'b1;

    snd_st_t          st;
    snd_st_t          st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [TOW-1:0]   tcnt;
    logic [TOW-1:0]   tcnt_nxt;

    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_dout;
    logic             pop;
    logic             push;
    logic             ovf_set;
    logic             lost_set;

    logic [7:0]       snd_latch_r;
    logic             snd_irq_r;
    logic             ovf_r;
    logic             lost_r;

    // A flush owns the cycle: it blocks both the pop and any same-cycle write
    assign pop     = (st == ST_IDLE) & ~fifo_empty & ~bus.flush;
    assign push    = bus.cmd_wr & ~bus.flush & (~fifo_full | pop);
    assign ovf_set = bus.cmd_wr & ~bus.flush & fifo_full & ~pop;

    jtdd_sndcmd_fifo #(
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush),
        .din   (bus.cmd_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        tcnt_nxt = tcnt;
        lost_set = 1'b0;
        case (st)
            ST_IDLE: begin
                if (pop) begin
                    st_nxt  = ST_SETUP;
                    cnt_nxt = '0;
                end
            end
            ST_SETUP: begin
                if (bus.flush) begin
                    st_nxt  = ST_GAP;
                    cnt_nxt = '0;
                end else if (cnt == SETUP_LAST) begin
                    st_nxt   = ST_IRQ;
                    tcnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_IRQ: begin
                // An ack on the final cycle still counts as delivered
                if (bus.flush || bus.snd_ack) begin
                    st_nxt  = ST_GAP;
                    cnt_nxt = '0;
                end else if (tcnt == TO_LAST) begin
                    st_nxt   = ST_GAP;
                    cnt_nxt  = '0;
                    lost_set = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    st_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st          <= ST_IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            snd_latch_r <= 8'h00;
            snd_irq_r   <= 1'b0;
            ovf_r       <= 1'b0;
            lost_r      <= 1'b0;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            tcnt      <= tcnt_nxt;
            snd_irq_r <= (st_nxt == ST_IRQ);
            if (pop) snd_latch_r <= fifo_dout;
            ovf_r     <= ovf_set  | (ovf_r  & ~bus.clr_flags);
            lost_r    <= lost_set | (lost_r & ~bus.clr_flags);
        end
    end

    assign bus.snd_latch = snd_latch_r;
    assign bus.snd_irq   = snd_irq_r;
    assign bus.busy      = ~fifo_empty | (st != ST_IDLE);
    assign bus.full      = fifo_full;
    assign bus.ovf       = ovf_r;
    assign bus.lost      = lost_r;

endmodule

// File: tb/tb_jtdd_sndcmd.sv
// Bench for jtdd_sndcmd: directed table, corner sequences and random traffic,
// every cycle compared with a timestamp-based model of the command handshake.
module tb_jtdd_sndcmd;
    localparam int AW    = 2;
    localparam int SETUP = 2;
    localparam int GAP   = 4;
    localparam int TOW   = 4;
    localparam int DEPTH = 1 << AW;
    localparam int TMAX  = (1 << TOW) - 1;

    logic clk;
    logic rstn;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    jtdd_sndcmd_if bus();

    jtdd_sndcmd #(
        .AW    (AW),
        .SETUP (SETUP),
        .GAP   (GAP),
        .TOW   (TOW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a byte queue plus the cycle numbers where IRQ rises and falls
    logic [7:0] q[$];
    logic [7:0] m_latch    = 8'h00;
    logic       m_ovf      = 1'b0;
    logic       m_lost     = 1'b0;
    logic       m_inflight = 1'b0;
    int         t_rise     = 0;
    int         t_fall     = 0;

    function automatic logic m_irq_at(int n);
        return m_inflight && n >= t_rise && n < t_fall;
    endfunction

    function automatic logic m_idle_at(int n);
        return !m_inflight || n >= t_fall + GAP;
    endfunction

    function automatic void chk8(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endfunction

    function automatic void chki(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endfunction

    // Advance the model across the edge that ends cycle 'cyc'
    function automatic void model_edge(logic rst, logic wr, logic [7:0] din,
                                       logic fl, logic ack, logic clr);
        int   n;
        logic irq_now;
        logic lost_ev;
        logic ovf_ev;
        n       = cyc;
        lost_ev = 1'b0;
        ovf_ev  = 1'b0;
        if (rst) begin
            q.delete();
            m_latch    = 8'h00;
            m_ovf      = 1'b0;
            m_lost     = 1'b0;
            m_inflight = 1'b0;
        end else begin
            irq_now = m_irq_at(n);
            if (fl) begin
                if (m_inflight && n < t_fall) t_fall = n + 1;
            end else if (irq_now && ack) begin
                t_fall = n + 1;
            end else if (irq_now && n == t_rise + TMAX - 1) begin
                lost_ev = 1'b1;
            end
            if (!fl && m_idle_at(n) && q.size() > 0) begin
                m_latch    = q.pop_front();
                m_inflight = 1'b1;
                t_rise     = n + 1 + SETUP;
                t_fall     = t_rise + TMAX;
            end
            if (wr && !fl) begin
                if (q.size() < DEPTH) q.push_back(din);
                else ovf_ev = 1'b1;
            end
            if (fl) q.delete();
            m_ovf  = ovf_ev  | (m_ovf  & ~clr);
            m_lost = lost_ev | (m_lost & ~clr);
        end
        cyc++;
    endfunction

    task automatic tick(input logic wr, input logic [7:0] din, input logic fl,
                        input logic ack, input logic clr, input logic rst);
        bus.cmd_wr    = wr;
        bus.cmd_din   = din;
        bus.flush     = fl;
        bus.snd_ack   = ack;
        bus.clr_flags = clr;
        rstn          = ~rst;
        @(posedge clk);
        model_edge(rst, wr, din, fl, ack, clr);
        #1;
        chk8("m_latch", bus.snd_latch, m_latch);
        chk1("m_irq",   bus.snd_irq,   m_irq_at(cyc));
        chk1("m_busy",  bus.busy,      q.size() > 0 || !m_idle_at(cyc));
        chk1("m_full",  bus.full,      q.size() == DEPTH);
        chk1("m_ovf",   bus.ovf,       m_ovf);
        chk1("m_lost",  bus.lost,      m_lost);
    endtask

    task automatic nop();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_rise(input int budget, output int lows);
        lows = 0;
        while (!bus.snd_irq && lows < budget) begin
            lows++;
            nop();
        end
        chk1("rise_seen", bus.snd_irq, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            n++;
            nop();
        end
        chk1("idle_reached", bus.busy, 1'b0);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       ack;
        logic [7:0] e_latch;
        logic       e_irq;
        logic       e_busy;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int   lows;
        int   hi;
        logic r_wr, r_fl, r_ack, r_clr, r_rst;

        // Row i: inputs during a cycle, outputs expected in the following cycle
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0}; // stray ack while idle
        tbl[1]  = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1}; // write, cycle 0
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1}; // stray ack in SETUP
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1}; // IRQ at cycle 4
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1}; // ack at cycle 10
        tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0}; // idle from cycle 15
        tbl[16] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0};

        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk8("rst_latch", bus.snd_latch, 8'h00);
        chk1("rst_irq",   bus.snd_irq,   1'b0);
        chk1("rst_busy",  bus.busy,      1'b0);
        chk1("rst_full",  bus.full,      1'b0);
        chk1("rst_ovf",   bus.ovf,       1'b0);
        chk1("rst_lost",  bus.lost,      1'b0);
        nop();

        // Single command with stray acks
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].wr, tbl[i].din, 1'b0, tbl[i].ack, 1'b0, 1'b0);
            chk8("tbl_latch", bus.snd_latch, tbl[i].e_latch);
            chk1("tbl_irq",   bus.snd_irq,   tbl[i].e_irq);
            chk1("tbl_busy",  bus.busy,      tbl[i].e_busy);
        end

        // Burst of five, delivered in order with fixed low spacing
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 8'(k + 1), 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 3) chk1("full_after4", bus.full, 1'b0);
            if (k == 4) chk1("full_after5", bus.full, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            wait_rise(30, lows);
            chk8("burst_byte", bus.snd_latch, 8'(k + 1));
            if (k > 0) chki("burst_lows", lows, GAP + 1 + SETUP);
            tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            chk1("burst_irq_drop", bus.snd_irq, 1'b0);
        end
        wait_idle(40);

        // Overflow with no acks; timeouts drain the queue
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 4) chk1("ovf_after5", bus.ovf, 1'b0);
            if (k == 5) chk1("ovf_after6", bus.ovf, 1'b1);
        end
        chk1("ovf_full", bus.full, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("ovf_clr", bus.ovf, 1'b0);
        wait_idle(300);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("lost_clr", bus.lost, 1'b0);

        // Timeout then next byte after the gap
        tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hB6, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_rise(30, lows);
        chk8("to_byte0", bus.snd_latch, 8'hA5);
        hi = 0;
        while (bus.snd_irq && hi < 40) begin
            hi++;
            nop();
        end
        chki("to_high_cycles", hi, TMAX);
        chk1("to_lost", bus.lost, 1'b1);
        wait_rise(30, lows);
        chk8("to_byte1", bus.snd_latch, 8'hB6);
        chki("to_lows", lows, GAP + 1 + SETUP);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle(40);

        // Reset in SETUP while lost is still set
        tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        nop();
        chk8("setup_latch", bus.snd_latch, 8'h5A);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk8("mid_rst_latch", bus.snd_latch, 8'h00);
        chk1("mid_rst_busy",  bus.busy,      1'b0);
        chk1("mid_rst_lost",  bus.lost,      1'b0);
        for (int k = 0; k < 8; k++) begin
            nop();
            chk1("mid_rst_no_irq", bus.snd_irq, 1'b0);
        end

        // Flush during IRQ with two queued, plus a discarded write
        tick(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_rise(30, lows);
        tick(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        chk1("fl_irq",   bus.snd_irq,   1'b0);
        chk8("fl_latch", bus.snd_latch, 8'h21);
        for (int k = 0; k < GAP - 1; k++) nop();
        chk1("fl_busy_gap", bus.busy, 1'b1);
        nop();
        chk1("fl_busy_end", bus.busy, 1'b0);
        chk8("fl_latch_end", bus.snd_latch, 8'h21);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            r_wr  = ($urandom_range(0, 99) < 30);
            r_fl  = ($urandom_range(0, 99) < 2);
            r_clr = ($urandom_range(0, 99) < 3);
            r_rst = ($urandom_range(0, 999) < 4);
            r_ack = bus.snd_irq ? ($urandom_range(0, 99) < 20)
                                : ($urandom_range(0, 99) < 3);
            tick(r_wr, 8'($urandom), r_fl, r_ack, r_clr, r_rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
